// File: rtl/mr_scoreboard.sv
// -----------------------------------------------------------------------------
// mr_scoreboard
//   Register scoreboard and issue controller for the mr decode stage.
//   Tracks pending writebacks per architectural register (x1..x31) and gates
//   issue from decode to the ALU stage on three hazards:
//     - RAW      : a used source register still has a pending write
//     - WAW-sat  : the destination's pending-write counter is saturated
//     - in-flight: MAX_INFLIGHT register writes are already outstanding
//   x0 is never tracked; it is neither a hazard source nor a destination.
//
// Optional feature (compile-time macro):
//   MR_SB_BYPASS_EN - when defined, a source read is not a RAW hazard if the
//   writeback port is retiring the last pending write to that same register
//   in the same cycle (decode forwards the WB value). Default: undefined.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous reset, active-low (0 = reset)
//   id_valid     in   decode holds an instruction wanting to issue
//   id_rs1       in   source register 1 select
//   id_rs1_used  in   instruction reads rs1
//   id_rs2       in   source register 2 select
//   id_rs2_used  in   instruction reads rs2
//   id_rd        in   destination register select
//   id_rd_wr     in   instruction writes rd
//   down_ready   in   ALU stage can accept
//   id_ready     out  issue permitted this cycle (combinational, no id_valid term)
//   wb_valid     in   writeback port active
//   wb_reg       in   writeback destination register
//   sb_inflight  out  outstanding tracked writes (registered)
//   sb_err       out  sticky: writeback to a register with no pending write
// -----------------------------------------------------------------------------

`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif

module mr_scoreboard #(
  parameter int CNT_BITS     = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              id_valid,
  input  logic [`REGSEL_BITS-1:0]           id_rs1,
  input  logic                              id_rs1_used,
  input  logic [`REGSEL_BITS-1:0]           id_rs2,
  input  logic                              id_rs2_used,
  input  logic [`REGSEL_BITS-1:0]           id_rd,
  input  logic                              id_rd_wr,
  input  logic                              down_ready,
  output logic                              id_ready,
  input  logic                              wb_valid,
  input  logic [`REGSEL_BITS-1:0]           wb_reg,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] sb_inflight,
  output logic                              sb_err
);

  localparam int REG_W = `REGSEL_BITS;
  localparam int NREG  = 1 << REG_W;
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  typedef logic [CNT_BITS-1:0] cnt_t;

  localparam cnt_t CNT_ONE = cnt_t'(1);
  localparam cnt_t CNT_SAT = '1;

  // Entry 0 exists only so register selects index the array directly;
  // it is held at zero and never incremented.
  cnt_t             pend_q [NREG];
  cnt_t             pend_d [NREG];
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic             sb_err_q, sb_err_d;

  // ---------------------------------------------------------------------------
  // Hazard detection (all on pre-update state)
  // ---------------------------------------------------------------------------
  logic rd_tracked;
  logic byp_rs1, byp_rs2;
  logic raw_rs1, raw_rs2;
  logic raw, waw, full;

  assign rd_tracked = id_rd_wr && (id_rd != '0);

`ifdef MR_SB_BYPASS_EN
  // The last pending write to this source retires this cycle, so decode can
  // take the value straight off the writeback bus.
  assign byp_rs1 = wb_valid && (wb_reg == id_rs1) && (pend_q[id_rs1] == CNT_ONE);
  assign byp_rs2 = wb_valid && (wb_reg == id_rs2) && (pend_q[id_rs2] == CNT_ONE);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  assign raw_rs1 = id_rs1_used && (id_rs1 != '0) && (pend_q[id_rs1] != '0) && !byp_rs1;
  assign raw_rs2 = id_rs2_used && (id_rs2 != '0) && (pend_q[id_rs2] != '0) && !byp_rs2;
  assign raw     = raw_rs1 || raw_rs2;

  // Blocking at saturation / at the in-flight limit is what keeps the
  // counters from wrapping; a same-cycle retire gives no credit here.
  assign waw  = rd_tracked && (pend_q[id_rd] == CNT_SAT);
  assign full = rd_tracked && (inflight_q == INF_W'(MAX_INFLIGHT));

  // No id_valid term: keeps the valid/ready handshake free of a comb loop.
  assign id_ready = rst && down_ready && !raw && !waw && !full;

  // ---------------------------------------------------------------------------
  // Issue / retire events
  // ---------------------------------------------------------------------------
  logic issue_wr;   // issue that allocates a tracked write
  logic retire_ok;  // writeback matching a pending write
  logic retire_bad; // writeback with nothing pending -> error

  assign issue_wr   = id_valid && id_ready && rd_tracked;
  assign retire_ok  = wb_valid && (wb_reg != '0) && (pend_q[wb_reg] != '0);
  assign retire_bad = wb_valid && (wb_reg != '0) && (pend_q[wb_reg] == '0);

  // ---------------------------------------------------------------------------
  // Next-state: net update per counter, so issue+retire on the same register
  // leaves it unchanged and issue+retire anywhere leaves inflight unchanged.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is given a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pend_d[0] = '0;
    for (int i = 1; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (issue_wr && (id_rd == REG_W'(i)) && !(retire_ok && (wb_reg == REG_W'(i))))
        pend_d[i] = pend_q[i] + CNT_ONE;
      else if (retire_ok && (wb_reg == REG_W'(i)) && !(issue_wr && (id_rd == REG_W'(i))))
        pend_d[i] = pend_q[i] - CNT_ONE;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (issue_wr && !retire_ok)
      inflight_d = inflight_q + INF_W'(1);
    else if (retire_ok && !issue_wr)
      inflight_d = inflight_q - INF_W'(1);
  end

  assign sb_err_d = sb_err_q || retire_bad;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  // NOTE: the pending counters are architectural state, not data storage: a
  // reset must clear them, so the whole array is reset, not just the control.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
      inflight_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
      inflight_q <= inflight_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign sb_inflight = inflight_q;
  assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_mr_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_mr_scoreboard
//   Directed bench for mr_scoreboard (CNT_BITS=2, MAX_INFLIGHT=4). Each step
//   drives one cycle of inputs and pushes the expected id_ready for that cycle
//   plus the expected registered sb_inflight / sb_err after the edge onto a
//   queue; the entry is popped and compared as the DUT produces those values.
// -----------------------------------------------------------------------------

module tb_mr_scoreboard;

  localparam int INF_W = $clog2(4 + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_rs1_used, id_rs2_used, id_rd_wr, down_ready, wb_valid;
  logic [4:0]       id_rs1, id_rs2, id_rd, wb_reg;
  logic             id_ready;
  logic [INF_W-1:0] sb_inflight;
  logic             sb_err;

  mr_scoreboard #(.CNT_BITS(2), .MAX_INFLIGHT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs1_used (id_rs1_used),
    .id_rs2      (id_rs2),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_rd_wr    (id_rd_wr),
    .down_ready  (down_ready),
    .id_ready    (id_ready),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .sb_inflight (sb_inflight),
    .sb_err      (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             ready;
    logic [INF_W-1:0] infl;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check id_ready mid-cycle, check state at
  // posedge+1 of the following edge (where the next step starts driving).
  task automatic step(input string tag,
                      input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic wr, input logic dn,
                      input logic wbv, input logic [4:0] wbr,
                      input logic er, input int ei, input logic ee);
    exp_t e;
    id_valid = v;  id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd;    id_rd_wr = wr; down_ready = dn; wb_valid = wbv; wb_reg = wbr;
    e.tag = tag; e.ready = er; e.infl = INF_W'(ei); e.err = ee;
    exp_q.push_back(e);
    #3;
    e = exp_q.pop_front();
    check({e.tag, ".ready"}, 32'(id_ready), 32'(e.ready));
    @(posedge clk);
    #1;
    check({e.tag, ".infl"}, 32'(sb_inflight), 32'(e.infl));
    check({e.tag, ".err"}, 32'(sb_err), 32'(e.err));
  endtask

  // Idle cycle with optional writeback only.
  task automatic wb(input string tag, input logic [4:0] r,
                    input logic er, input int ei, input logic ee);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 1, 1, r, er, ei, ee);
  endtask

  // Issue attempt writing rd, no sources.
  task automatic iss(input string tag, input logic [4:0] rd,
                     input logic er, input int ei, input logic ee);
    step(tag, 1, 0, 0, 0, 0, rd, 1, 1, 0, 0, er, ei, ee);
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wr = 0; down_ready = 1; wb_valid = 0; wb_reg = 0;
    @(posedge clk);
    #1;

    // Reset: id_ready held low even with no hazard.
    iss("rst0", 5'd5, 0, 0, 0);
    iss("rst1", 5'd5, 0, 0, 0);
    rst = 1'b1;

    // 1: RAW on rs1 through pending rd=5.
    iss("t1_issue", 5'd5, 1, 1, 0);
    step("t1_raw", 1, 5'd5, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
`ifdef MR_SB_BYPASS_EN
    step("t1_wb", 1, 5'd5, 1, 0, 0, 0, 0, 1, 1, 5'd5, 1, 0, 0);
`else
    step("t1_wb", 1, 5'd5, 1, 0, 0, 0, 0, 1, 1, 5'd5, 0, 0, 0);
`endif
    step("t1_after", 1, 5'd5, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);

    // 2: x0 destinations / sources never tracked.
    for (int i = 0; i < 10; i++)
      step($sformatf("t2_x0_%0d", i), 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 0, 0);

    // 3: saturation of pend[7] at 3.
    iss("t3_i1", 5'd7, 1, 1, 0);
    iss("t3_i2", 5'd7, 1, 2, 0);
    iss("t3_i3", 5'd7, 1, 3, 0);
    iss("t3_sat", 5'd7, 0, 3, 0);
    // Retire same cycle gives no WAW credit.
    step("t3_wbsat", 1, 0, 0, 0, 0, 5'd7, 1, 1, 1, 5'd7, 0, 2, 0);
    iss("t3_reissue", 5'd7, 1, 3, 0);
    wb("t3_d1", 5'd7, 1, 2, 0);
    wb("t3_d2", 5'd7, 1, 1, 0);
    wb("t3_d3", 5'd7, 1, 0, 0);

    // 4: in-flight limit.
    iss("t4_r1", 5'd1, 1, 1, 0);
    iss("t4_r2", 5'd2, 1, 2, 0);
    iss("t4_r3", 5'd3, 1, 3, 0);
    iss("t4_r4", 5'd4, 1, 4, 0);
    iss("t4_full", 5'd6, 0, 4, 0);
    step("t4_wbfull", 1, 0, 0, 0, 0, 5'd6, 1, 1, 1, 5'd2, 0, 3, 0);
    iss("t4_accept", 5'd6, 1, 4, 0);
    // Unused source on a pending register is no hazard.
    step("t4_unused", 1, 5'd1, 0, 5'd3, 0, 0, 0, 1, 0, 0, 1, 4, 0);
    // Non-writing instruction ignores full.
    step("t4_nowr", 1, 0, 0, 0, 0, 5'd9, 0, 1, 0, 0, 1, 4, 0);

    // 5: same-cycle issue and retire on x3.
    wb("t5_d1", 5'd1, 1, 3, 0);
    wb("t5_d4", 5'd4, 1, 2, 0);
    wb("t5_d6", 5'd6, 1, 1, 0);
    step("t5_both", 1, 0, 0, 0, 0, 5'd3, 1, 1, 1, 5'd3, 1, 1, 0);
    step("t5_rs2raw", 1, 0, 0, 5'd3, 1, 0, 0, 1, 0, 0, 0, 1, 0);
    wb("t5_wb3", 5'd3, 1, 0, 0);
    step("t5_rs2ok", 1, 0, 0, 5'd3, 1, 0, 0, 1, 0, 0, 1, 0, 0);

    // 6: sticky error, then reset discards tracking.
    wb("t6_err", 5'd9, 1, 0, 1);
    step("t6_sticky", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1);
    iss("t6_iss12", 5'd12, 1, 1, 1);
    rst = 1'b0;
    iss("t6_rst", 5'd12, 0, 0, 0);
    rst = 1'b1;
    step("t6_clear", 1, 5'd12, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    wb("t6_stale", 5'd12, 1, 0, 1);
    rst = 1'b0;
    iss("t6_rst2", 5'd12, 0, 0, 0);
    rst = 1'b1;

    // 7: down_ready low blocks issue and state.
    step("t7_stall", 1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0);
    step("t7_nochg", 1, 5'd8, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
